// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among NUM_REQ byte sources with round-robin
// arbitration. A byte is launched with a one-cycle tx_en pulse. The arbiter
// then follows the transmitter's busy level (bps_en): it waits for busy to
// rise, then for busy to fall, and then holds an optional idle gap before the
// next launch. If busy never rises after a launch, the byte is abandoned and a
// sticky error flag is set.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester byte-available level
//   req_data     byte of requester i at bits [8i+7:8i]
//   req_ready    one-cycle pulse: byte of requester i accepted
//   tx_en        one-cycle launch pulse to uart_tx
//   tx_data      byte to uart_tx, held from one launch until the next
//   tx_busy      bps_en from uart_tx, high while a frame is in flight
//   err_clr      clears err_timeout
//   busy         high whenever the arbiter is not idle
//   cur_owner    index of the last granted requester
//   byte_count   bytes whose busy-rise was observed (wraps at 16 bits)
//   err_timeout  sticky: a launched byte never raised tx_busy
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int  NUM_REQ       = 4,
    parameter int  GAP_CYCLES    = 16,
    parameter int  START_TIMEOUT = 64,
    localparam int OWNER_W       = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    input  logic                   err_clr,
    output logic                   busy,
    output logic [OWNER_W-1:0]     cur_owner,
    output logic [15:0]            byte_count,
    output logic                   err_timeout
);

    // ------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------
    // Candidate sums (pointer + offset) must hold values up to 2*NUM_REQ-1.
    localparam int SUM_W = OWNER_W + 1;
    // The timeout counter counts 0 .. START_TIMEOUT-1.
    localparam int TO_W  = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);
    // The gap counter is loaded with GAP_CYCLES and counts down to 1.
    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    // With a zero gap, the GAP state is never entered.
    localparam bit GAP_EN = (GAP_CYCLES != 0);

    localparam logic [OWNER_W-1:0] PTR_INIT = OWNER_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(START_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0]   GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_WAIT_DONE  = 2'd2,
        ST_GAP        = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t               state_reg;
    logic [OWNER_W-1:0]   ptr_reg;
    logic [TO_W-1:0]      to_cnt_reg;
    logic [GAP_W-1:0]     gap_cnt_reg;
    logic [NUM_REQ-1:0]   req_ready_reg;
    logic                 tx_en_reg;
    logic [7:0]           tx_data_reg;
    logic                 busy_reg;
    logic [OWNER_W-1:0]   cur_owner_reg;
    logic [15:0]          byte_count_reg;
    logic                 err_timeout_reg;

    assign req_ready   = req_ready_reg;
    assign tx_en       = tx_en_reg;
    assign tx_data     = tx_data_reg;
    assign busy        = busy_reg;
    assign cur_owner   = cur_owner_reg;
    assign byte_count  = byte_count_reg;
    assign err_timeout = err_timeout_reg;

    // ------------------------------------------------------------------
    // Round-robin grant
    // ------------------------------------------------------------------
    // cand_idx[k] is the requester examined at search position k. Position
    // 0 is the requester just after the pointer, so the last winner has the
    // lowest priority.
    logic [7:0]         req_byte [NUM_REQ];
    logic [SUM_W-1:0]   cand_sum [NUM_REQ];
    logic [OWNER_W-1:0] cand_idx [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign req_byte[gi] = req_data[8*gi +: 8];
            assign cand_sum[gi] = {1'b0, ptr_reg} + SUM_W'(gi + 1);
            // Wrap modulo NUM_REQ. The sum is below 2*NUM_REQ, so a single
            // conditional subtract is enough, even for non-power-of-two counts.
            assign cand_idx[gi] = (cand_sum[gi] >= SUM_W'(NUM_REQ))
                                ? OWNER_W'(cand_sum[gi] - SUM_W'(NUM_REQ))
                                : cand_sum[gi][OWNER_W-1:0];
        end
    endgenerate

    logic               grant_valid;
    logic [OWNER_W-1:0] grant_idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        // Scan from the lowest priority to the highest, so the
        // highest-priority valid requester writes last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    logic [NUM_REQ-1:0] grant_onehot;
    assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            ptr_reg         <= PTR_INIT;
            to_cnt_reg      <= '0;
            gap_cnt_reg     <= '0;
            req_ready_reg   <= '0;
            tx_en_reg       <= 1'b0;
            tx_data_reg     <= '0;
            busy_reg        <= 1'b0;
            cur_owner_reg   <= '0;
            byte_count_reg  <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            // The launch strobes last exactly one cycle.
            tx_en_reg     <= 1'b0;
            req_ready_reg <= '0;

            // The clear is written first, so a timeout in the same cycle
            // overrides it below.
            if (err_clr) begin
                err_timeout_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    // A transmitter that is still busy (for example, after a
                    // reset of this block only) holds off every launch.
                    if (!tx_busy && grant_valid) begin
                        tx_en_reg     <= 1'b1;
                        req_ready_reg <= grant_onehot;
                        tx_data_reg   <= req_byte[grant_idx];
                        cur_owner_reg <= grant_idx;
                        ptr_reg       <= grant_idx;
                        to_cnt_reg    <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_WAIT_START;
                    end
                end

                ST_WAIT_START: begin
                    if (tx_busy) begin
                        byte_count_reg <= byte_count_reg + 16'd1;
                        state_reg      <= ST_WAIT_DONE;
                    end else if (to_cnt_reg == TO_LAST) begin
                        // The byte is dropped. The requester already got its
                        // ready pulse and is not signalled again.
                        err_timeout_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                        state_reg       <= ST_IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end

                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (GAP_EN) begin
                            gap_cnt_reg <= GAP_LOAD;
                            state_reg   <= ST_GAP;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_reg == GAP_ONE) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                    end
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. It uses a simple uart_tx stand-in that
// raises busy one cycle after tx_en and holds it for BUSY_LEN cycles. The
// stand-in can be switched off, and tx_busy then follows force_busy. A table
// of arbitration vectors checks round-robin order, data routing and pulse
// widths. Hand-written sequences cover:
//   - the inter-frame gap,
//   - the start timeout and the priority of set over clear,
//   - busy at reset release,
//   - reset in the middle of a frame,
//   - byte counter wrap.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int GAP_CYCLES    = 16;
    localparam int START_TIMEOUT = 64;
    localparam int BUSY_LEN      = 110;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [31:0]  req_data;
    logic [3:0]   req_ready;
    logic         tx_en;
    logic [7:0]   tx_data;
    logic         tx_busy;
    logic         err_clr;
    logic         busy;
    logic [1:0]   cur_owner;
    logic [15:0]  byte_count;
    logic         err_timeout;

    logic         model_en;
    logic         force_busy;
    int           model_cnt = 0;
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .GAP_CYCLES    (GAP_CYCLES),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .err_clr     (err_clr),
        .busy        (busy),
        .cur_owner   (cur_owner),
        .byte_count  (byte_count),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in
    always @(posedge clk) begin
        if (model_en && tx_en) model_cnt <= BUSY_LEN;
        else if (model_cnt != 0) model_cnt <= model_cnt - 1;
    end
    assign tx_busy = model_en ? (model_cnt != 0) : force_busy;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  owner;
        logic [7:0]  byte_exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Waits for a tx_en pulse, sampled on falling edges. Returns the cycle
    // stamp, or -1 (and records a failure) if the wait times out.
    task automatic wait_tx_en(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tx_en === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL wait_tx_en: no launch within %0d cycles", limit);
        end
    endtask

    // sel 0: the arbiter's busy output; sel 1: tx_busy.
    task automatic wait_sig(input string name, input int sel, input logic val, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (((sel == 0) ? busy : tx_busy) === val) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: level %0b not reached within %0d cycles", name, val, limit);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        int t0;
        int f_cyc;
        int cnt;

        vecs[0]  = '{4'b1111, 32'h13121110, 2'd0, 8'h10};
        vecs[1]  = '{4'b1111, 32'h13121110, 2'd1, 8'h11};
        vecs[2]  = '{4'b1111, 32'h13121110, 2'd2, 8'h12};
        vecs[3]  = '{4'b1111, 32'h13121110, 2'd3, 8'h13};
        vecs[4]  = '{4'b1111, 32'h13121110, 2'd0, 8'h10};
        vecs[5]  = '{4'b1010, 32'hB3B2B1B0, 2'd1, 8'hB1};
        vecs[6]  = '{4'b1010, 32'hB3B2B1B0, 2'd3, 8'hB3};
        vecs[7]  = '{4'b0101, 32'hDEADBEEF, 2'd0, 8'hEF};
        vecs[8]  = '{4'b0110, 32'h0F1E2D3C, 2'd1, 8'h2D};
        vecs[9]  = '{4'b0100, 32'h0F1E2D3C, 2'd2, 8'h1E};
        vecs[10] = '{4'b0001, 32'h000000FF, 2'd0, 8'hFF};
        vecs[11] = '{4'b1000, 32'h80000000, 2'd3, 8'h80};

        // ---- reset state ----
        rst_n = 1'b0; req_valid = '0; req_data = '0; err_clr = 1'b0;
        model_en = 1'b1; force_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst req_ready",   32'(req_ready),   32'h0);
        check("rst tx_en",       32'(tx_en),       32'h0);
        check("rst tx_data",     32'(tx_data),     32'h0);
        check("rst busy",        32'(busy),        32'h0);
        check("rst cur_owner",   32'(cur_owner),   32'h0);
        check("rst byte_count",  32'(byte_count),  32'h0);
        check("rst err_timeout", 32'(err_timeout), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- table: round-robin order and data routing ----
        // Each new vector is presented right after the previous ready pulse,
        // as a requester with back-to-back bytes would do.
        for (int i = 0; i < 12; i++) begin
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            wait_tx_en(300, at);
            check($sformatf("v%0d owner", i), 32'(cur_owner), 32'(vecs[i].owner));
            check($sformatf("v%0d tx_data", i), 32'(tx_data), 32'(vecs[i].byte_exp));
            check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(4'b0001 << vecs[i].owner));
            check($sformatf("v%0d byte_count", i), 32'(byte_count), 32'(i));
            @(negedge clk);
            check($sformatf("v%0d strobes low", i), 32'({tx_en, req_ready}), 32'h0);
        end
        req_valid = '0;
        wait_sig("table drain", 0, 1'b0, 300);
        check("table byte_count", 32'(byte_count), 32'd12);

        // ---- single byte launch latency, then gap before the next launch ----
        req_valid = 4'b0100; req_data = 32'h00A50000;
        t0 = cyc;
        wait_tx_en(5, at);
        check("single latency", 32'(at - t0), 32'd1);
        check("single tx_data", 32'(tx_data), 32'hA5);
        check("single req_ready", 32'(req_ready), 32'b0100);
        check("single owner", 32'(cur_owner), 32'd2);
        req_valid = 4'b0001; req_data = 32'h0000005A;
        wait_sig("single busy rise", 1, 1'b1, 10);
        wait_sig("single busy fall", 1, 1'b0, 200);
        f_cyc = cyc;
        check("single byte_count", 32'(byte_count), 32'd13);
        wait_tx_en(100, at);
        check("gap launch delay", 32'(at - f_cyc), 32'(GAP_CYCLES + 2));
        check("gap owner", 32'(cur_owner), 32'd0);
        check("gap tx_data", 32'(tx_data), 32'h5A);
        req_valid = '0;
        wait_sig("gap drain", 0, 1'b0, 300);

        // ---- start timeout ----
        model_en = 1'b0; force_busy = 1'b0;
        @(negedge clk);
        req_valid = 4'b0010; req_data = 32'h00007E00;
        wait_tx_en(5, at);
        req_valid = '0;
        cnt = 0;
        repeat (63) begin
            @(negedge clk);
            if (tx_en) cnt++;
        end
        check("timeout err early", 32'(err_timeout), 32'h0);
        @(negedge clk);
        check("timeout err set", 32'(err_timeout), 32'h1);
        check("timeout back idle", 32'(busy), 32'h0);
        check("timeout single tx_en", 32'(cnt), 32'h0);
        check("timeout byte_count", 32'(byte_count), 32'd14);
        check("timeout tx_data", 32'(tx_data), 32'h7E);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr clears", 32'(err_timeout), 32'h0);

        // ---- timeout coinciding with err_clr: set wins ----
        err_clr = 1'b1;
        req_valid = 4'b0010;
        wait_tx_en(5, at);
        req_valid = '0;
        check("setwins owner", 32'(cur_owner), 32'd1);
        repeat (63) @(negedge clk);
        check("setwins before", 32'(err_timeout), 32'h0);
        @(negedge clk);
        check("setwins set", 32'(err_timeout), 32'h1);
        @(negedge clk);
        check("setwins clr after", 32'(err_timeout), 32'h0);
        err_clr = 1'b0;

        // ---- transmitter busy at reset release ----
        rst_n = 1'b0; force_busy = 1'b1; model_en = 1'b0;
        req_valid = 4'b0001; req_data = 32'h000000C3;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_en) cnt++;
        end
        check("busyidle no launch", 32'(cnt), 32'h0);
        check("busyidle busy", 32'(busy), 32'h0);
        force_busy = 1'b0; model_en = 1'b1;
        t0 = cyc;
        wait_tx_en(5, at);
        req_valid = '0;
        check("busyidle latency", 32'(at - t0), 32'd1);
        check("busyidle owner", 32'(cur_owner), 32'd0);
        check("busyidle tx_data", 32'(tx_data), 32'hC3);

        // ---- reset in WAIT_DONE ----
        wait_sig("midrst busy rise", 1, 1'b1, 10);
        repeat (5) @(negedge clk);
        check("midrst in frame", 32'({busy, byte_count}), 32'h10001);
        rst_n = 1'b0;
        #1;
        check("midrst tx_en",       32'(tx_en),       32'h0);
        check("midrst req_ready",   32'(req_ready),   32'h0);
        check("midrst tx_data",     32'(tx_data),     32'h0);
        check("midrst busy",        32'(busy),        32'h0);
        check("midrst byte_count",  32'(byte_count),  32'h0);
        check("midrst err_timeout", 32'(err_timeout), 32'h0);
        req_valid = 4'b1111; req_data = 32'h44332211;
        @(negedge clk);
        rst_n = 1'b1;
        wait_tx_en(300, at);
        req_valid = '0;
        check("midrst first owner", 32'(cur_owner), 32'd0);
        check("midrst first ready", 32'(req_ready), 32'b0001);
        check("midrst first data", 32'(tx_data), 32'h11);
        wait_sig("midrst drain", 0, 1'b0, 300);

        // ---- byte counter wrap ----
        @(negedge clk);
        force dut.byte_count_reg = 16'hFFFE;
        @(negedge clk);
        release dut.byte_count_reg;
        @(negedge clk);
        check("wrap preload", 32'(byte_count), 32'hFFFE);
        req_valid = 4'b1000; req_data = 32'h55000000;
        wait_tx_en(10, at);
        wait_sig("wrap rise 1", 1, 1'b1, 10);
        @(negedge clk);
        check("wrap FFFF", 32'(byte_count), 32'hFFFF);
        wait_tx_en(300, at);
        req_valid = '0;
        wait_sig("wrap rise 2", 1, 1'b1, 10);
        @(negedge clk);
        check("wrap 0000", 32'(byte_count), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
